message_loader: RTL
===================

Name: message_loader

Overview:
Writer side of the scrolling-message path. Users enter a message of up to 16 four-bit character codes from switches, one code per debounced press of a load button. The block holds the codes in an internal 16-entry message memory. A combinational read port lets the display/scroll logic fetch any position by address, with positions beyond the current message length returning a fill code.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles (after sync) needed before a button level change is accepted; must be >= 2
FILL_CHAR, 4'b1101, code returned for read addresses >= msg_len (dash)
MAX_LEN, 16, message capacity; fixed, equals memory depth

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all control state
sw_char  input  4  character code to store, sampled on the write edge
load_btn  input  1  raw asynchronous push button; a debounced press appends sw_char
clear_btn  input  1  raw asynchronous push button; a debounced press empties the message
rd_addr  input  4  read position from the display side
rd_char  output  4  combinational: mem[rd_addr] if rd_addr < msg_len, else FILL_CHAR
msg_len  output  5  number of stored characters, 0..16
empty  output  1  msg_len == 0
full  output  1  msg_len == 16
overflow  output  1  sticky; set by a load press while full
wr_ack  output  1  one-cycle pulse on the edge a character is written

Behaviour:
- Reset (async, immediate):
  - msg_len=0, write pointer=0, overflow=0, wr_ack=0, state=EMPTY.
  - Sync and debounce flops = 0, debounced levels = 0.
  - Memory contents are not reset; they are masked by msg_len on read.
- Button path, per button, identical for load_btn and clear_btn:
  - 2-flop synchronizer.
  - Debounce counter: resets whenever the synced level equals the debounced level. Otherwise it counts up; after DEBOUNCE_CYCLES consecutive differing cycles the debounced level takes the synced value and the counter clears.
  - Rising edge of the debounced level gives a one-cycle internal press pulse. Release generates nothing.
- Latency: with the button held high from before sampling edge E0, the write/clear commits at edge E0 + DEBOUNCE_CYCLES + 3. wr_ack is high during the following cycle.
- Glitches: a pulse (high or low) shorter than DEBOUNCE_CYCLES synced cycles is ignored entirely.
- Holding a button produces exactly one press. The next press requires a debounced release first.
- State machine, states EMPTY, PARTIAL, FULL:
  - EMPTY --load--> PARTIAL
  - PARTIAL --load with msg_len==15--> FULL
  - PARTIAL --load with msg_len<15--> PARTIAL
  - any state --clear--> EMPTY
  - FULL --load--> FULL with overflow set; no write, no wr_ack
- Load write, when not FULL: mem[wr_ptr] <= sw_char; wr_ptr <= wr_ptr+1 (4-bit, wraps 15->0 only as it enters FULL); msg_len <= msg_len+1; wr_ack pulse.
- Clear: msg_len=0, wr_ptr=0, overflow=0, no wr_ack. Memory is untouched.
- Simultaneous load and clear press pulses on the same edge: clear wins and the load is dropped.
- Reset mid-debounce discards any pending press.
- Read port:
  - Purely combinational; it sees a new write in the cycle after the write edge.
  - rd_addr compare is 5-bit: {1'b0, rd_addr} < msg_len.
- empty and full are decoded from state, not registered separately. They must agree with msg_len on every cycle.

Test Plan:
Use DEBOUNCE_CYCLES=4 throughout.
1. Reset, then hold load_btn high with sw_char=4'h3 -> wr_ack pulses once, exactly 7 edges after the first sampling edge; msg_len=1; rd_addr=0 gives 4'h3; rd_addr=1 gives 4'hD.
2. Sixteen presses with sw_char=0..15, then a 17th press with sw_char=4'h7 -> after 16: full=1, msg_len=16, rd_addr=k gives k. After the 17th: overflow=1, mem[0] still 0, no wr_ack.
3. load_btn high for 3 synced cycles, then low; separately, a 2-cycle low dropout during a held press -> no write, and only one write for the held press.
4. Load and clear pressed with identical timing, message length 5 -> msg_len=0, empty=1, overflow=0, no wr_ack, all reads return 4'hD.
5. Assert reset while the load debounce counter is at 2 -> after release, msg_len=0 and no write occurs without a fresh full-length press.
6. After clear, load 4'hA -> mem[0]=4'hA, msg_len=1; rd_addr=1 returns 4'hD even though stale data sits there.

Source files
------------

// File: rtl/message_loader.sv
// Scrolling-message writer: debounced load/clear buttons append 4-bit codes
// to a 16-entry message memory with a length-masked combinational read port.
module message_loader_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Level is only accepted after a full run of differing synced samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

module message_loader #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [3:0] FILL_CHAR       = 4'b1101,
  parameter int         MAX_LEN         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_char,
  input  logic       load_btn,
  input  logic       clear_btn,
  input  logic [3:0] rd_addr,
  output logic [3:0] rd_char,
  output logic [4:0] msg_len,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       wr_ack
);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  localparam logic [4:0] LEN_LAST = 5'(MAX_LEN - 1);

  logic [1:0] state;
  logic [3:0] wr_ptr;
  logic [3:0] mem [MAX_LEN];
  logic       load_press;
  logic       clear_press;
  logic       wr_en;

  message_loader_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_db (
    .clk  (clk),
    .reset(reset),
    .btn  (load_btn),
    .press(load_press)
  );

  message_loader_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk  (clk),
    .reset(reset),
    .btn  (clear_btn),
    .press(clear_press)
  );

  // Clear has priority; a load while full only flags overflow.
  assign wr_en = load_press & ~clear_press & (state != ST_FULL);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sw_char;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_EMPTY;
      msg_len  <= 5'd0;
      wr_ptr   <= 4'd0;
      overflow <= 1'b0;
      wr_ack   <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      if (clear_press) begin
        state    <= ST_EMPTY;
        msg_len  <= 5'd0;
        wr_ptr   <= 4'd0;
        overflow <= 1'b0;
      end else if (load_press) begin
        if (state == ST_FULL) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr  <= wr_ptr + 4'd1;
          msg_len <= msg_len + 5'd1;
          wr_ack  <= 1'b1;
          state   <= (msg_len == LEN_LAST) ? ST_FULL : ST_PARTIAL;
        end
      end
    end
  end

  assign empty = (state == ST_EMPTY);
  assign full  = (state == ST_FULL);

  assign rd_char = ({1'b0, rd_addr} < msg_len) ? mem[rd_addr] : FILL_CHAR;

endmodule
